// File: rtl/sine_lut.sv
// ---------------------------------------------------------------------------
// sine_lut
//
// Quarter-wave sine generator. Maps a 13-bit phase index in the first
// quadrant to an unsigned 15-bit magnitude (held in a 16-bit output whose
// MSB is always 0). A 129-entry quarter-wave table is linearly interpolated
// across 64 fractional steps per segment. The result is registered, so it
// appears exactly one clock after v is presented. The caller handles
// quadrant folding and sign.
//
// Ports
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset, clears sv
//   v      in  13   phase index, 0 = 0 rad, 8191 = just below pi/2
//   sv     out 16   sine magnitude 0..32767, bit 15 always 0
// ---------------------------------------------------------------------------
module sine_lut (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] v,
    output logic [15:0] sv
);

    localparam int TABLE_LEN = 129;

    // round(32767 * sin((pi/2) * i / 128)), i = 0..128. Entry 128 exists so
    // the last segment has an upper endpoint to interpolate towards.
    localparam logic [14:0] SINE_TABLE [TABLE_LEN] = '{
        15'd0,     15'd402,   15'd804,   15'd1206,  15'd1608,  15'd2009,  15'd2410,  15'd2811,
        15'd3212,  15'd3612,  15'd4011,  15'd4410,  15'd4808,  15'd5205,  15'd5602,  15'd5998,
        15'd6393,  15'd6786,  15'd7179,  15'd7571,  15'd7962,  15'd8351,  15'd8739,  15'd9126,
        15'd9512,  15'd9896,  15'd10278, 15'd10659, 15'd11039, 15'd11417, 15'd11793, 15'd12167,
        15'd12539, 15'd12910, 15'd13279, 15'd13645, 15'd14010, 15'd14372, 15'd14732, 15'd15090,
        15'd15446, 15'd15800, 15'd16151, 15'd16499, 15'd16846, 15'd17189, 15'd17530, 15'd17869,
        15'd18204, 15'd18537, 15'd18868, 15'd19195, 15'd19519, 15'd19841, 15'd20159, 15'd20475,
        15'd20787, 15'd21096, 15'd21403, 15'd21705, 15'd22005, 15'd22301, 15'd22594, 15'd22884,
        15'd23170, 15'd23452, 15'd23731, 15'd24007, 15'd24279, 15'd24547, 15'd24811, 15'd25072,
        15'd25329, 15'd25582, 15'd25832, 15'd26077, 15'd26319, 15'd26556, 15'd26790, 15'd27019,
        15'd27245, 15'd27466, 15'd27683, 15'd27896, 15'd28105, 15'd28310, 15'd28510, 15'd28706,
        15'd28898, 15'd29085, 15'd29268, 15'd29447, 15'd29621, 15'd29791, 15'd29956, 15'd30117,
        15'd30273, 15'd30424, 15'd30571, 15'd30714, 15'd30852, 15'd30985, 15'd31113, 15'd31237,
        15'd31356, 15'd31470, 15'd31580, 15'd31685, 15'd31785, 15'd31880, 15'd31971, 15'd32057,
        15'd32137, 15'd32213, 15'd32285, 15'd32351, 15'd32412, 15'd32469, 15'd32521, 15'd32567,
        15'd32609, 15'd32646, 15'd32678, 15'd32705, 15'd32728, 15'd32745, 15'd32757, 15'd32765,
        15'd32767
    };

    // Segment indices are 8 bits wide so seg_hi can reach entry 128.
    logic [7:0]         seg_lo;
    logic [7:0]         seg_hi;
    logic [5:0]         frac;
    logic signed [23:0] base_s;
    logic signed [23:0] next_s;
    logic signed [23:0] delta_s;
    logic signed [23:0] prod_s;
    logic signed [23:0] interp_s;
    logic [14:0]        sat_val;
    logic [15:0]        sv_next;
    logic [15:0]        sv_reg;

    always_comb begin
        seg_lo  = {1'b0, v[12:6]};
        seg_hi  = seg_lo + 8'd1;
        frac    = v[5:0];
        base_s  = $signed({9'd0, SINE_TABLE[seg_lo]});
        next_s  = $signed({9'd0, SINE_TABLE[seg_hi]});
        delta_s = next_s - base_s;
        // 24-bit signed headroom: |delta| < 2^15 and frac < 2^6, so the
        // product never exceeds 22 bits. +32 rounds the >>6 to nearest.
        prod_s   = delta_s * $signed({18'd0, frac});
        interp_s = base_s + ((prod_s + 24'sd32) >>> 6);

        // Clamp into 0..32767 so bit 15 of the output can never be set.
        if (interp_s < 24'sd0) begin
            sat_val = '0;
        end else if (interp_s > 24'sd32767) begin
            sat_val = 15'h7FFF;
        end else begin
            sat_val = interp_s[14:0];
        end
        sv_next = {1'b0, sat_val};
    end

    // Single output register: gives the one-cycle latency and isolates v
    // from sv combinationally. Reset clears it without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv_reg <= '0;
        end else begin
            sv_reg <= sv_next;
        end
    end

    assign sv = sv_reg;

endmodule

// File: tb/tb_sine_lut.sv
// ---------------------------------------------------------------------------
// tb_sine_lut
//
// Self-checking bench for sine_lut. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge. Directed vectors
// carry hand-computed results of the interpolated table; the full sweep is
// checked against the ideal sine (within 2 LSB) and for monotonicity.
// ---------------------------------------------------------------------------
module tb_sine_lut;

    localparam real PI = 3.14159265358979323846;

    logic        clk;
    logic        rst_n;
    logic [12:0] v;
    logic [15:0] sv;

    int errors;
    int checks;

    sine_lut dut (
        .clk   (clk),
        .rst_n (rst_n),
        .v     (v),
        .sv    (sv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison; report it if |got - exp| exceeds tol.
    task automatic check(input string tag, input int got, input int exp, input int tol);
        int diff;
        checks++;
        diff = (got > exp) ? (got - exp) : (exp - got);
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ideal(input int idx);
        return int'(32767.0 * $sin(PI * real'(idx) / 16384.0));
    endfunction

    // Present one value, then check the registered result after the edge.
    task automatic apply(input string tag, input int val, input int exp);
        @(negedge clk);
        v = 13'(val);
        @(posedge clk);
        #1;
        $display("txn %-16s v=%0d sv=%0d exp=%0d", tag, val, sv, exp);
        check(tag, int'(sv), exp, 0);
    endtask

    // Directed vectors: f(v) from the table, worked out by hand.
    localparam int NVEC = 13;
    int vec_v   [NVEC] = '{0, 1, 2048, 8191, 63, 64, 100, 1234, 4095, 4096, 6000, 8128, 8190};
    int vec_exp [NVEC] = '{0, 6, 12539, 32767, 396, 402, 628, 7681, 23166, 23170, 29915, 32765, 32767};

    initial begin
        int prev;
        int exp_val;
        int max_err;
        int e;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        v      = 13'd4096;

        // Reset held with clock running: output stays at 0.
        repeat (3) @(posedge clk);
        #1;
        $display("txn %-16s v=%0d sv=%0d exp=0", "rst_hold", v, sv);
        check("rst_hold", int'(sv), 0, 0);

        // Release: the very next edge loads f(4096).
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("txn %-16s v=%0d sv=%0d exp=23170", "rst_release", v, sv);
        check("rst_release", int'(sv), 23170, 0);

        // Directed vectors on consecutive cycles (0, 1, 2048 lead the table).
        for (int k = 0; k < NVEC; k++) begin
            apply($sformatf("vec%0d", vec_v[k]), vec_v[k], vec_exp[k]);
            if (vec_v[k] == 8191) begin
                check("v8191_bit15", int'(sv[15]), 0, 0);
            end
        end

        // Toggle 8191 / 0: before each edge sv must still show the previous
        // result; after it, the new one.
        @(negedge clk);
        v = 13'd0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v = (k % 2 == 0) ? 13'd8191 : 13'd0;
            #1;
            check("toggle_pre", int'(sv), (k % 2 == 0) ? 0 : 32767, 0);
            @(posedge clk);
            #1;
            $display("txn %-16s v=%0d sv=%0d exp=%0d", "toggle", v, sv, (k % 2 == 0) ? 32767 : 0);
            check("toggle_post", int'(sv), (k % 2 == 0) ? 32767 : 0, 0);
        end

        // Short sweep interrupted by an asynchronous reset pulse.
        for (int k = 5995; k <= 6000; k++) begin
            @(negedge clk);
            v = 13'(k);
            @(posedge clk);
            #1;
            check("pre_rst_sweep", int'(sv), ideal(k), 2);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn %-16s v=%0d sv=%0d exp=0", "async_rst", v, sv);
        check("async_rst", int'(sv), 0, 0);
        @(posedge clk);
        #1;
        check("rst_mid_hold", int'(sv), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("txn %-16s v=%0d sv=%0d exp=29915", "resume", v, sv);
        check("resume", int'(sv), 29915, 0);
        for (int k = 6001; k <= 6005; k++) begin
            @(negedge clk);
            v = 13'(k);
            @(posedge clk);
            #1;
            check("post_rst_sweep", int'(sv), ideal(k), 2);
        end

        // Exhaustive sweep: accuracy against the ideal curve and monotonicity.
        prev    = 0;
        max_err = 0;
        for (int k = 0; k < 8192; k++) begin
            @(negedge clk);
            v = 13'(k);
            @(posedge clk);
            #1;
            exp_val = ideal(k);
            check("sweep", int'(sv), exp_val, 2);
            check("mono", (int'(sv) < prev) ? 1 : 0, 0, 0);
            e = (int'(sv) > exp_val) ? int'(sv) - exp_val : exp_val - int'(sv);
            if (e > max_err) max_err = e;
            prev = int'(sv);
        end
        $display("txn %-16s v=0..8191 max_err=%0d last_sv=%0d", "sweep", max_err, prev);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
